// File: rtl/alu_src_b_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_src_b_pkg
// Description : Shared select codes for the ALU source-B operand stage.
// Revision    : 1.0 - initial pipelined release
// ============================================================================
package alu_src_b_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SRC_B_REG      = 3'd0;
  localparam logic [SEL_W-1:0] SRC_B_CONST    = 3'd1;
  localparam logic [SEL_W-1:0] SRC_B_SEXT     = 3'd2;
  localparam logic [SEL_W-1:0] SRC_B_SEXT_SH2 = 3'd3;
  localparam logic [SEL_W-1:0] SRC_B_ZEXT     = 3'd4;
  localparam logic [SEL_W-1:0] SRC_B_UPPER    = 3'd5;
  localparam logic [SEL_W-1:0] SRC_B_SHAMT    = 3'd6;
  localparam logic [SEL_W-1:0] SRC_B_ILLEGAL  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/alu_src_b_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_src_b_stage_if
// Description : Operand-in / operand-out handshake bundle of the source-B stage.
// Revision    : 1.0 - initial pipelined release
// ============================================================================
interface alu_src_b_stage_if
  import alu_src_b_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] b_reg;
  logic [IMM_W-1:0] imm;
  logic [SEL_W-1:0] alu_src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             err_illegal;
  logic             err_clr;

  // Producer / consumer side driving the stage
  modport master (
    output in_valid, b_reg, imm, alu_src_b, out_ready, err_clr,
    input  in_ready, out_valid, out_data, err_illegal
  );

  // The stage itself
  modport slave (
    input  in_valid, b_reg, imm, alu_src_b, out_ready, err_clr,
    output in_ready, out_valid, out_data, err_illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_src_b_ext.sv
`default_nettype none
// ============================================================================
// Module      : alu_src_b_ext
// Description : Combinational source-B select and immediate extension.
// Revision    : 1.0 - initial pipelined release
// ============================================================================
module alu_src_b_ext
  import alu_src_b_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IMM_W  = 16,
  parameter int PC_INC = 4
) (
  input  wire logic [WIDTH-1:0] i_b_reg,
  input  wire logic [IMM_W-1:0] i_imm,
  input  wire logic [SEL_W-1:0] i_sel,
  output logic      [WIDTH-1:0] o_value,
  output logic                  o_illegal
);

  logic [WIDTH-1:0] w_sext;
  logic [WIDTH-1:0] w_zext;

  assign w_sext = {{(WIDTH-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  assign w_zext = {{(WIDTH-IMM_W){1'b0}}, i_imm};

  // Operand mux; every code is decoded, code 7 yields zero and flags illegal
  always_comb begin
    o_value   = '0;
    o_illegal = 1'b0;
    case (i_sel)
      SRC_B_REG:      o_value = i_b_reg;
      SRC_B_CONST:    o_value = WIDTH'(PC_INC);
      SRC_B_SEXT:     o_value = w_sext;
      SRC_B_SEXT_SH2: o_value = {w_sext[WIDTH-3:0], 2'b00};
      SRC_B_ZEXT:     o_value = w_zext;
      SRC_B_UPPER:    o_value = {i_imm, {(WIDTH-IMM_W){1'b0}}};
      SRC_B_SHAMT:    o_value = {{(WIDTH-5){1'b0}}, i_imm[10:6]};
      default: begin
        o_value   = '0;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_src_b_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_src_b_stage
// Description : Registered ALU source-B operand stage with valid/ready
//               handshake and a one-entry skid buffer.
// Revision    : 1.0 - initial pipelined release
// ============================================================================
module alu_src_b_stage
  import alu_src_b_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IMM_W  = 16,
  parameter int PC_INC = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  alu_src_b_stage_if.slave  bus
);

  logic [WIDTH-1:0] w_value;
  logic             w_illegal;
  logic             w_accept;
  logic             w_out_load;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_full;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_err_illegal;

  alu_src_b_ext #(
    .WIDTH  (WIDTH),
    .IMM_W  (IMM_W),
    .PC_INC (PC_INC)
  ) u_ext (
    .i_b_reg   (bus.b_reg),
    .i_imm     (bus.imm),
    .i_sel     (bus.alu_src_b),
    .o_value   (w_value),
    .o_illegal (w_illegal)
  );

  // The skid holds the only backlog, so readiness is just "skid empty".
  // A full skid therefore never sees a simultaneous fill.
  assign w_accept   = bus.in_valid && !r_skid_full;
  assign w_out_load = !r_out_valid || bus.out_ready;

  // Output register: the skid entry is older, so it takes priority over new input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_out_load) begin
      if (r_skid_full) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_skid_data;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_value;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Skid entry: filled when the output is stalled, drained when the output loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_full <= 1'b0;
      r_skid_data <= '0;
    end else if (r_skid_full) begin
      if (w_out_load) begin
        r_skid_full <= 1'b0;
      end
    end else if (w_accept && !w_out_load) begin
      r_skid_full <= 1'b1;
      r_skid_data <= w_value;
    end
  end

  // Sticky illegal-select flag; a new illegal accept beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_illegal <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err_illegal <= 1'b1;
    end else if (bus.err_clr) begin
      r_err_illegal <= 1'b0;
    end
  end

  assign bus.in_ready    = !r_skid_full;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.err_illegal = r_err_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_src_b_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_src_b_stage
// Description : Self-checking bench for alu_src_b_stage (32- and 64-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_src_b_stage;
  import alu_src_b_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_src_b_stage_if #(.WIDTH(32), .IMM_W(16)) bus ();
  alu_src_b_stage_if #(.WIDTH(64), .IMM_W(16)) bus64 ();

  alu_src_b_stage #(.WIDTH(32), .IMM_W(16), .PC_INC(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_src_b_stage #(.WIDTH(64), .IMM_W(16), .PC_INC(8)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] b,
                       input logic [15:0] imm);
    bus.in_valid  = v;
    bus.alu_src_b = sel;
    bus.b_reg     = b;
    bus.imm       = imm;
  endtask

  function automatic logic [31:0] model(input logic [2:0] sel, input logic [31:0] b,
                                        input logic [15:0] imm);
    case (sel)
      3'd0:    return b;
      3'd1:    return 32'd4;
      3'd2:    return {{16{imm[15]}}, imm};
      3'd3:    return {{14{imm[15]}}, imm, 2'b00};
      3'd4:    return {16'h0000, imm};
      3'd5:    return {imm, 16'h0000};
      3'd6:    return {27'd0, imm[10:6]};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] q[$];
    logic        prev_stall;
    logic [31:0] prev_data;
    int          accepted;
    int          cyc;

    vecs[0] = '{SRC_B_REG,      32'h1234_5678, 1'b0};
    vecs[1] = '{SRC_B_CONST,    32'h0000_0004, 1'b0};
    vecs[2] = '{SRC_B_SEXT,     32'hFFFF_8004, 1'b0};
    vecs[3] = '{SRC_B_SEXT_SH2, 32'hFFFE_0010, 1'b0};
    vecs[4] = '{SRC_B_ZEXT,     32'h0000_8004, 1'b0};
    vecs[5] = '{SRC_B_UPPER,    32'h8004_0000, 1'b0};
    vecs[6] = '{SRC_B_SHAMT,    32'h0000_0000, 1'b0};
    vecs[7] = '{SRC_B_ILLEGAL,  32'h0000_0000, 1'b1};

    drive(1'b0, 3'd0, 32'h0, 16'h0);
    bus.out_ready    = 1'b1;
    bus.err_clr      = 1'b0;
    bus64.in_valid   = 1'b0;
    bus64.alu_src_b  = 3'd0;
    bus64.b_reg      = 64'h0;
    bus64.imm        = 16'h0;
    bus64.out_ready  = 1'b1;
    bus64.err_clr    = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_err", 64'(bus.err_illegal), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Select sweep, one result per cycle, each one cycle after accept
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].sel, 32'h1234_5678, 16'h8004);
      step();
      chk($sformatf("sweep%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("sweep%0d_data", i), 64'(bus.out_data), 64'(vecs[i].exp_data));
      chk($sformatf("sweep%0d_err", i), 64'(bus.err_illegal), 64'(vecs[i].exp_err));
    end
    drive(1'b0, 3'd0, 32'h0, 16'h0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("sweep_err_cleared", 64'(bus.err_illegal), 64'd0);
    chk("sweep_idle_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: three operands against a stalled consumer
    bus.out_ready = 1'b0;
    drive(1'b1, SRC_B_SEXT, 32'h0, 16'd1);
    step();
    chk("bp1_valid", 64'(bus.out_valid), 64'd1);
    chk("bp1_data", 64'(bus.out_data), 64'd1);
    chk("bp1_in_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, SRC_B_SEXT, 32'h0, 16'd2);
    step();
    chk("bp2_data", 64'(bus.out_data), 64'd1);
    chk("bp2_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, SRC_B_SEXT, 32'h0, 16'd3);
    step();
    chk("bp3_data_held", 64'(bus.out_data), 64'd1);
    chk("bp3_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_rel2_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_rel2_data", 64'(bus.out_data), 64'd2);
    chk("bp_rel2_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    drive(1'b0, 3'd0, 32'h0, 16'h0);
    chk("bp_rel3_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_rel3_data", 64'(bus.out_data), 64'd3);
    step();
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    // Error flag: set beats clear, then clear alone
    drive(1'b1, SRC_B_ILLEGAL, 32'h0, 16'h0);
    bus.err_clr = 1'b1;
    step();
    chk("err_set_wins", 64'(bus.err_illegal), 64'd1);
    drive(1'b0, 3'd0, 32'h0, 16'h0);
    step();
    chk("err_clr_alone", 64'(bus.err_illegal), 64'd0);
    bus.err_clr = 1'b0;
    step();

    // Sustained random stream against a FIFO scoreboard
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    accepted   = 0;
    cyc        = 0;
    while (accepted < 100 && cyc < 2000) begin
      cyc++;
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", 64'(bus.out_data), 64'(prev_data));
      end
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 16'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: unexpected operand %h, expected none", bus.out_data);
        end else begin
          chk("sb_data", 64'(bus.out_data), 64'(q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.alu_src_b, bus.b_reg, bus.imm));
        accepted++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      step();
    end
    if (accepted < 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL stream_budget: accepted %0d, required 100", accepted);
    end
    drive(1'b0, 3'd0, 32'h0, 16'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: unexpected operand %h, expected none", bus.out_data);
        end else begin
          chk("sb_drain", 64'(bus.out_data), 64'(q.pop_front()));
        end
      end
      step();
    end
    chk("sb_empty", 64'(q.size()), 64'd0);
    chk("sb_idle_valid", 64'(bus.out_valid), 64'd0);

    // Reset mid-stream with the skid full and the error flag set
    bus.out_ready = 1'b0;
    drive(1'b1, SRC_B_ILLEGAL, 32'h0, 16'h0);
    step();
    drive(1'b1, SRC_B_REG, 32'hDEAD_BEEF, 16'h0);
    step();
    chk("pre_rst_skid_full", 64'(bus.in_ready), 64'd0);
    chk("pre_rst_err", 64'(bus.err_illegal), 64'd1);
    drive(1'b0, 3'd0, 32'h0, 16'h0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(bus.out_data), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_err", 64'(bus.err_illegal), 64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_no_output", 64'(bus.out_valid), 64'd0);

    // 64-bit build with PC_INC = 8
    bus64.in_valid  = 1'b1;
    bus64.alu_src_b = SRC_B_CONST;
    step();
    chk("w64_const", bus64.out_data, 64'h8);
    bus64.alu_src_b = SRC_B_SEXT_SH2;
    bus64.imm       = 16'hFFFF;
    step();
    chk("w64_sext_sh2", bus64.out_data, 64'hFFFF_FFFF_FFFF_FFFC);
    bus64.in_valid  = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
